// File: rtl/axi_lite_adder_master_if.sv
// AXI4-Lite bus between the adder master and the adder peripheral.
// Ports (master view): AW/W/AR address, data and valid out; B/R responses in;
// bready/rready out. awprot/arprot and wstrb are carried for completeness.
interface axi_lite_adder_master_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input  bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input  rdata, rresp, rvalid, output rready
  );

  modport slave (
    input  awaddr, awprot, awvalid, output awready,
    input  wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input  araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/axi_lite_adder_master.sv
// AXI4-Lite initiator for the memory-mapped adder peripheral.
// Accepts (cmd_a, cmd_b) on a valid/ready command port, writes A then B into
// the peripheral, waits SETTLE_CYCLES, reads the sum back and returns it with
// an error flag (any non-zero BRESP/RRESP) on a valid/ready response port.
// Ports: clk, reset (async, active high); cmd_valid/cmd_ready/cmd_a/cmd_b;
// rsp_valid/rsp_ready/rsp_sum/rsp_err; busy; m_axi (AXI4-Lite master).
module axi_lite_adder_master #(
  parameter int                    ADDR_WIDTH    = 4,
  parameter int                    DATA_WIDTH    = 32,
  parameter logic [ADDR_WIDTH-1:0] A_OFFSET      = 'h0,
  parameter logic [ADDR_WIDTH-1:0] B_OFFSET      = 'h4,
  parameter logic [ADDR_WIDTH-1:0] SUM_OFFSET    = 'h8,
  parameter int unsigned           SETTLE_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [DATA_WIDTH-1:0] cmd_a,
  input  logic [DATA_WIDTH-1:0] cmd_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_sum,
  output logic                  rsp_err,
  output logic                  busy,
  axi_lite_adder_master_if.master m_axi
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  typedef enum logic [3:0] {
    IDLE, WR_A, B_A, WR_B, B_B, SETTLE, RD_A, RD_D, RESP
  } state_t;

  state_t                state, state_nxt;
  logic                  aw_done, w_done;
  logic [DATA_WIDTH-1:0] a_q, b_q, sum_q;
  logic                  err_q;
  logic [CNT_W-1:0]      cnt;

  logic in_wr, awv, wv, aw_hs, w_hs, wr_both, settle_last;

  // Every AXI output is a decode of flops only (state, aw_done, w_done,
  // latched operands), so nothing combinational reaches the bus from inputs.
  assign in_wr       = (state == WR_A) || (state == WR_B);
  assign awv         = in_wr && !aw_done;
  assign wv          = in_wr && !w_done;
  assign aw_hs       = awv && m_axi.awready;
  assign w_hs        = wv && m_axi.wready;
  // AW and W may complete in either order; leave once both have been seen.
  assign wr_both     = (aw_done || aw_hs) && (w_done || w_hs);
  assign settle_last = (cnt == CNT_W'(SETTLE_CYCLES - 1));

  assign m_axi.awvalid = awv;
  assign m_axi.wvalid  = wv;
  assign m_axi.awaddr  = (state == WR_A) ? A_OFFSET : (state == WR_B) ? B_OFFSET : '0;
  assign m_axi.wdata   = (state == WR_A) ? a_q : (state == WR_B) ? b_q : '0;
  assign m_axi.awprot  = 3'b000;
  assign m_axi.arprot  = 3'b000;
  assign m_axi.wstrb   = '1;
  assign m_axi.bready  = (state == B_A) || (state == B_B);
  assign m_axi.arvalid = (state == RD_A);
  assign m_axi.araddr  = (state == RD_A) ? SUM_OFFSET : '0;
  assign m_axi.rready  = (state == RD_D);

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign rsp_valid = (state == RESP);
  assign rsp_sum   = sum_q;
  assign rsp_err   = err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (cmd_valid)      state_nxt = WR_A;
      WR_A:   if (wr_both)        state_nxt = B_A;
      B_A:    if (m_axi.bvalid)   state_nxt = WR_B;
      WR_B:   if (wr_both)        state_nxt = B_B;
      B_B:    if (m_axi.bvalid)   state_nxt = (SETTLE_CYCLES == 0) ? RD_A : SETTLE;
      SETTLE: if (settle_last)    state_nxt = RD_A;
      RD_A:   if (m_axi.arready)  state_nxt = RD_D;
      RD_D:   if (m_axi.rvalid)   state_nxt = RESP;
      RESP:   if (rsp_ready)      state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      err_q   <= 1'b0;
      cnt     <= '0;
    end else begin
      if (state == IDLE && cmd_valid) begin
        a_q   <= cmd_a;
        b_q   <= cmd_b;
        err_q <= 1'b0;
      end
      if (in_wr) begin
        // Done flags live only for the current write; clear on exit.
        if (wr_both) begin
          aw_done <= 1'b0;
          w_done  <= 1'b0;
        end else begin
          if (aw_hs) aw_done <= 1'b1;
          if (w_hs)  w_done  <= 1'b1;
        end
      end
      if ((state == B_A || state == B_B) && m_axi.bvalid)
        err_q <= err_q | (m_axi.bresp != 2'b00);
      if (state == B_B)   cnt <= '0;
      if (state == SETTLE) cnt <= cnt + CNT_W'(1);
      if (state == RD_D && m_axi.rvalid) begin
        sum_q <= m_axi.rdata;
        err_q <= err_q | (m_axi.rresp != 2'b00);
      end
    end
  end

endmodule
